// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port word memory between
// an instruction-fetch port and a load/store port; sub-word stores run as read-modify-write.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rsp_valid,
  output logic [31:0]           i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in,
  output logic                  mem_we
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           i_rsp_q, i_rsp_d;
  logic [31:0]           d_rsp_q, d_rsp_d;
  logic                  grant_data_s, accept_i_s, accept_d_s;
  logic                  full_s, partial_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int n = 0; n < 4; n++) begin
      res[8*n +: 8] = strb[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
    end
    return res;
  endfunction

  // On a tie the port that did not win last time gets the grant.
  assign grant_data_s = d_req_valid & (~i_req_valid | (last_grant_q == PORT_FETCH));
  assign accept_i_s   = resetn & (state_q == S_IDLE) & i_req_valid & ~grant_data_s;
  assign accept_d_s   = resetn & (state_q == S_IDLE) & grant_data_s;
  assign i_req_ready  = accept_i_s;
  assign d_req_ready  = accept_d_s;

  assign full_s    = we_q & (wstrb_q == 4'b1111);
  assign partial_s = we_q & (wstrb_q != 4'b1111) & (wstrb_q != 4'b0000);

  // State and request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      last_grant_q <= PORT_FETCH;
      port_q       <= PORT_FETCH;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 4'b0000;
      old_q        <= 32'h0000_0000;
      i_rsp_q      <= 32'h0000_0000;
      d_rsp_q      <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      old_q        <= old_d;
      i_rsp_q      <= i_rsp_d;
      d_rsp_q      <= d_rsp_d;
    end
  end

  // Sequencer next state; response registers load only on entry to RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    old_d        = old_q;
    i_rsp_d      = i_rsp_q;
    d_rsp_d      = d_rsp_q;
    case (state_q)
      S_IDLE: begin
        if (accept_i_s | accept_d_s) begin
          state_d      = S_ACCESS;
          last_grant_d = accept_d_s;
          port_d       = accept_d_s;
          if (accept_d_s) begin
            addr_d  = d_addr & WORD_MASK;
            we_d    = d_we;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end else begin
            addr_d  = i_addr & WORD_MASK;
            we_d    = 1'b0;
            wdata_d = wdata_q;
            wstrb_d = 4'b0000;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        old_d = mem_data_in;
        if (partial_s) begin
          state_d = S_MERGE;
        end else if (port_q == PORT_FETCH) begin
          state_d = S_RESP;
          i_rsp_d = mem_data_in;
        end else begin
          state_d = S_RESP;
          d_rsp_d = mem_data_in;
        end
      end
      S_MERGE: begin
        state_d = S_RESP;
        d_rsp_d = old_q;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobe and data come from state alone, so reset cancels a pending write.
  always_comb begin
    mem_we       = 1'b0;
    mem_data_out = wdata_q;
    case (state_q)
      S_ACCESS: begin
        if (full_s) begin
          mem_we = 1'b1;
        end else begin
          mem_we = 1'b0;
        end
      end
      S_MERGE: begin
        mem_we       = 1'b1;
        mem_data_out = merge_lanes(old_q, wdata_q, wstrb_q);
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign mem_address = addr_q;
  assign i_rsp_valid = (state_q == S_RESP) & (port_q == PORT_FETCH);
  assign d_rsp_valid = (state_q == S_RESP) & (port_q != PORT_FETCH);
  assign i_rsp_data  = i_rsp_q;
  assign d_rsp_data  = d_rsp_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port 16 KB word memory. It shares the memory between the instruction-fetch port (read-only) and the load/store port (read/write with byte strobes), using round-robin arbitration. Sub-word stores become a read-modify-write sequence, because the memory writes whole words only. Memory read is combinational and memory write commits on the `posedge clk` where `mem_we`=1.

## Interface
- `ADDR_WIDTH`, 32, byte-address width of requests and of `mem_address`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  fetch request; held high with stable `i_addr` until accepted.
- `i_req_ready`  out  1  fetch request accepted this cycle when `i_req_valid`&`i_req_ready`.
- `i_addr`  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- `i_rsp_valid`  out  1  one-cycle pulse: `i_rsp_data` valid.
- `i_rsp_data`  out  32  fetched word.
- `d_req_valid`  in  1  load/store request; held with stable fields until accepted.
- `d_req_ready`  out  1  load/store request accepted this cycle.
- `d_addr`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `d_we`  in  1  1 = store, 0 = load.
- `d_wdata`  in  32  store data, already lane-aligned.
- `d_wstrb`  in  4  byte-lane enables for stores; bit n covers bits [8n+7:8n].
- `d_rsp_valid`  out  1  one-cycle pulse: load data or store completion.
- `d_rsp_data`  out  32  memory word as it was before the access.
- `mem_address`  out  ADDR_WIDTH  to memory address; bits [1:0] always 0.
- `mem_data_out`  out  32  to memory write data.
- `mem_data_in`  in  32  from memory combinational read data.
- `mem_we`  out  1  to memory write enable.

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - `i_req_ready`/`d_req_ready` are combinational and asserted only to the granted requester, and only when that requester is valid.
  - Grant rule: if only one requester is valid, that one is granted. If both are valid, the requester not granted last time wins.
  - `last_grant` resets to FETCH, so the first tie goes to data.
  - On accept: latch port ID, address (with [1:0] cleared), `we`, `wdata` and `wstrb`; update `last_grant`; go to ACCESS.
- ACCESS:
  - `mem_address` = latched address.
  - Capture `mem_data_in` into the response register (`old`).
  - Load or fetch: go to RESP.
  - Store with `wstrb`=4'b1111: `mem_we`=1, `mem_data_out`=`wdata`; go to RESP.
  - Store with `wstrb`=4'b0000: no write; go to RESP.
  - Any other `wstrb`: go to MERGE.
- MERGE:
  - `mem_we`=1.
  - `mem_data_out` = per byte lane, `wstrb` ? `wdata` : `old`.
  - Go to RESP.
- RESP:
  - Assert `rsp_valid` of the latched port for exactly one cycle, with `rsp_data`=`old`; the other port's `rsp_valid` stays 0.
  - Go to IDLE.
- Responses have no backpressure; requesters must accept them.
- `mem_we` is decoded from state and is never 1 outside ACCESS (full-word store) or MERGE.
- `mem_data_out` outside write cycles: the latched `wdata`.
- `mem_address` outside ACCESS/MERGE: holds the last latched address.
- `rsp_data` registers hold their value between pulses.
- Only one request is outstanding at any time.

## Timing
- Accept at cycle T (valid&ready at edge T).
- Load or fetch: ACCESS at T+1, `rsp_valid` at T+2, next accept at T+3.
- Full-word or zero-strobe store: memory written at the end of T+1, `rsp_valid` at T+2.
- Partial store: read at T+1, write at the end of T+2, `rsp_valid` at T+3, next accept at T+4.
- Reset values, applied immediately on `resetn` low: state IDLE, `last_grant` FETCH, and all outputs 0 (`i/d_req_ready`, `i/d_rsp_valid`, `i/d_rsp_data`, `mem_address`, `mem_data_out`, `mem_we`).
- Reset mid-operation: the in-flight request is dropped with no response. `mem_we` drops asynchronously, so a MERGE write is cancelled if reset asserts before its edge.
- A requester that drops valid before being accepted is simply not served; no state changes.

## Test plan
- Fetch read:
  - Stimulus: memory word 3 = 0x00500093, `i_req_valid` with `i_addr`=0x0C.
  - Required: `i_req_ready` at T, `i_rsp_valid` at T+2 with 0x00500093, `mem_we` never 1.
- Full store then load:
  - Stimulus: store 0xDEADBEEF, `wstrb` 1111, at 0x100, then load 0x100.
  - Required: store ack at T+2 with `d_rsp_data`=old word 0; load returns 0xDEADBEEF.
- Partial store:
  - Stimulus: word at 0x40 = 0x11223344; store `wdata` 0xAABBCCDD, `wstrb` 0110.
  - Required: `mem_we` only at T+2 with `mem_data_out`=0x11BBCC44; ack at T+3.
- Contention:
  - Stimulus: both ports valid continuously from reset.
  - Required: grants alternate D,I,D,I; each port gets one response per 6 cycles (reads); no response pulses overlap.
- Reset mid-MERGE:
  - Stimulus: deassert `resetn` during MERGE.
  - Required: `mem_we` goes 0 immediately, memory word unchanged, no `d_rsp_valid`, and after release the next request is served normally.
- Unaligned address:
  - Stimulus: `i_addr`=0x0F.
  - Required: `mem_address`=0x0C and word 3 is returned.
